mem_wb: RTL and testbench

The MEM/WB pipeline register of the five-stage CPU. It sits between the data-memory stage and the write-back stage. On every clock edge it captures the memory-stage results and write-back control bits, so that write-back sees a stable copy for one full cycle. It has no stall or flush inputs and is a pure one-cycle delay with synchronous clear.

---
 rtl/cpu_pkg.sv | 13 +
 rtl/pipe_reg.sv | 20 ++
 rtl/mem_wb.sv | 64 ++++++
 tb/tb_mem_wb.sv | 139 +++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants: datapath widths and the write-back source select encoding.
package cpu_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int SEL_W      = 2;

  localparam logic [SEL_W-1:0] WB_SEL_ALU  = 2'b00;
  localparam logic [SEL_W-1:0] WB_SEL_MEM  = 2'b01;
  localparam logic [SEL_W-1:0] WB_SEL_PC4  = 2'b10;
  localparam logic [SEL_W-1:0] WB_SEL_RSVD = 2'b11;

endpackage

// File: rtl/pipe_reg.sv
// Generic pipeline register: loads d_i every edge, synchronous active-high clear wins.
module pipe_reg #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk) begin
    if (rst) data_q <= '0;
    else     data_q <= d_i;
  end

  assign q_o = data_q;

endmodule

// File: rtl/mem_wb.sv
// MEM/WB pipeline register: one-cycle registered copy of memory-stage results and WB control.
// Optional simulation checks (reserved select with write enable, X/Z on outputs) under MEM_WB_CHECK_EN.
module mem_wb #(
  parameter int DATA_W     = cpu_pkg::DATA_W,
  parameter int REG_ADDR_W = cpu_pkg::REG_ADDR_W,
  parameter int SEL_W      = cpu_pkg::SEL_W
) (
  input  logic                  RegWrite_in,
  input  logic [SEL_W-1:0]      MemtoReg_in,
  input  logic [DATA_W-1:0]     D_MEM_read_data_in,
  input  logic [DATA_W-1:0]     D_MEM_read_addr_in,
  input  logic [DATA_W-1:0]     PC_plus_4_in,
  input  logic [REG_ADDR_W-1:0] EX_MEM_RegisterRd_in,
  input  logic                  clk,
  input  logic                  rst,
  output logic [DATA_W-1:0]     D_MEM_read_data_out,
  output logic [DATA_W-1:0]     D_MEM_read_addr_out,
  output logic [DATA_W-1:0]     PC_plus_4_out,
  output logic [REG_ADDR_W-1:0] MEM_WB_RegisterRd_out,
  output logic                  RegWrite_out,
  output logic [SEL_W-1:0]      MemtoReg_out
);
  import cpu_pkg::*;

  localparam int BUS_W = 1 + SEL_W + 3 * DATA_W + REG_ADDR_W;

  logic [BUS_W-1:0] bus_d;
  logic [BUS_W-1:0] bus_q;

  // Everything travels as one flat bus; no field is decoded or masked here.
  assign bus_d = {RegWrite_in, MemtoReg_in, D_MEM_read_data_in, D_MEM_read_addr_in,
                  PC_plus_4_in, EX_MEM_RegisterRd_in};

  pipe_reg #(.WIDTH(BUS_W)) u_pipe_reg (
    .clk (clk),
    .rst (rst),
    .d_i (bus_d),
    .q_o (bus_q)
  );

  assign {RegWrite_out, MemtoReg_out, D_MEM_read_data_out, D_MEM_read_addr_out,
          PC_plus_4_out, MEM_WB_RegisterRd_out} = bus_q;

`ifdef MEM_WB_CHECK_EN
  logic chk_armed_q;
  logic chk_known_q;

  always @(posedge clk) begin
    chk_armed_q <= 1'b1;
    chk_known_q <= (rst === 1'b1) || ((rst === 1'b0) && !$isunknown(bus_d));
  end

  // Checked mid-cycle so the flops have settled after the edge.
  always @(negedge clk) begin
    if (chk_armed_q === 1'b1) begin
      if (chk_known_q && $isunknown(bus_q))
        $error("mem_wb: X/Z on outputs after a defined edge");
      if (RegWrite_out === 1'b1 && MemtoReg_out === WB_SEL_RSVD)
        $warning("mem_wb: reserved MemtoReg select with RegWrite asserted");
    end
  end
`endif

endmodule

// File: tb/tb_mem_wb.sv
// Scoreboard bench for mem_wb: stimulus pushes the expected post-edge outputs, a monitor pops and compares.
module tb_mem_wb;
  import cpu_pkg::*;

  typedef struct packed {
    logic                  rw;
    logic [SEL_W-1:0]      m2r;
    logic [DATA_W-1:0]     rdata;
    logic [DATA_W-1:0]     addr;
    logic [DATA_W-1:0]     pc4;
    logic [REG_ADDR_W-1:0] rd;
  } wb_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  wb_t  din = '0;

  logic [DATA_W-1:0]     rdata_o, addr_o, pc4_o;
  logic [REG_ADDR_W-1:0] rd_o;
  logic                  rw_o;
  logic [SEL_W-1:0]      m2r_o;

  mem_wb dut (
    .RegWrite_in           (din.rw),
    .MemtoReg_in           (din.m2r),
    .D_MEM_read_data_in    (din.rdata),
    .D_MEM_read_addr_in    (din.addr),
    .PC_plus_4_in          (din.pc4),
    .EX_MEM_RegisterRd_in  (din.rd),
    .clk                   (clk),
    .rst                   (rst),
    .D_MEM_read_data_out   (rdata_o),
    .D_MEM_read_addr_out   (addr_o),
    .PC_plus_4_out         (pc4_o),
    .MEM_WB_RegisterRd_out (rd_o),
    .RegWrite_out          (rw_o),
    .MemtoReg_out          (m2r_o)
  );

  always #5 clk = ~clk;

  wb_t exp_q[$];
  int  total = 0;
  int  bad   = 0;
  wb_t last_exp;
  bit  have_last = 1'b0;

  function automatic wb_t cur();
    wb_t a;
    a.rw = rw_o; a.m2r = m2r_o; a.rdata = rdata_o;
    a.addr = addr_o; a.pc4 = pc4_o; a.rd = rd_o;
    return a;
  endfunction

  function automatic wb_t mk(input logic rw, input logic [SEL_W-1:0] m2r,
                             input logic [DATA_W-1:0] rdata, input logic [DATA_W-1:0] addr,
                             input logic [DATA_W-1:0] pc4, input logic [REG_ADDR_W-1:0] rd);
    wb_t v;
    v.rw = rw; v.m2r = m2r; v.rdata = rdata; v.addr = addr; v.pc4 = pc4; v.rd = rd;
    return v;
  endfunction

  task automatic check(input string name, input wb_t act, input wb_t req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got rw=%b sel=%b data=%h addr=%h pc4=%h rd=%0d, required rw=%b sel=%b data=%h addr=%h pc4=%h rd=%0d",
               name, act.rw, act.m2r, act.rdata, act.addr, act.pc4, act.rd,
               req.rw, req.m2r, req.rdata, req.addr, req.pc4, req.rd);
    end
  endtask

  // Model: after an edge, outputs are zero if rst was high at that edge, else the inputs seen there.
  // With glitch set, rst pulses high between edges and must be ignored.
  task automatic step(input logic r, input wb_t v, input bit glitch);
    wb_t e;
    @(negedge clk);
    din = v;
    rst = r;
    if (glitch) begin
      rst = 1'b1;
      #2;
      rst = 1'b0;
    end
    #1;
    if (have_last) check("hold_before_edge", cur(), last_exp);
    e = (rst === 1'b1) ? wb_t'('0) : v;
    exp_q.push_back(e);
    last_exp  = e;
    have_last = 1'b1;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) check("after_edge", cur(), exp_q.pop_front());
    end
  end

  initial begin
    wb_t v;
    int  left;

    step(1'b1, mk(1'b1, WB_SEL_RSVD, '1, '1, '1, 5'd31), 1'b0);
    step(1'b0, mk(1'b1, WB_SEL_MEM, 32'hDEADBEEF, 32'h00001000, 32'h00000044, 5'd5), 1'b0);

    for (int i = 0; i < 2000; i++) begin
      v.rw    = 1'($urandom);
      v.m2r   = SEL_W'($urandom);
      v.rdata = $urandom;
      v.addr  = $urandom;
      v.pc4   = $urandom;
      v.rd    = REG_ADDR_W'($urandom);
      step(($urandom_range(0, 31) == 0), v, 1'b0);
    end

    step(1'b0, mk(1'b1, WB_SEL_ALU, 32'h12345678, 32'h12345678, 32'h12345678, 5'd7), 1'b0);
    step(1'b1, mk(1'b1, WB_SEL_PC4, 32'hCAFEF00D, 32'hCAFEF00D, 32'hCAFEF00D, 5'd9), 1'b0);
    step(1'b0, mk(1'b0, WB_SEL_MEM, 32'h0BADC0DE, 32'h00002000, 32'h00000100, 5'd12), 1'b0);

    step(1'b0, mk(1'b1, WB_SEL_RSVD, 32'h55AA55AA, 32'hAA55AA55, 32'h00000008, 5'd0), 1'b0);
    step(1'b0, mk(1'b1, WB_SEL_PC4, 32'h89ABCDEF, 32'h76543210, 32'h00000ABC, 5'd17), 1'b1);
    step(1'b0, mk(1'b0, WB_SEL_ALU, 32'h0, 32'h0, 32'h0, 5'd0), 1'b0);

    @(posedge clk);
    #2;
    left = exp_q.size();
    total++;
    if (left != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expectations, required 0", left);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
